// File: rtl/pc_run_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_run_ctrl_pkg
// Shared types and constants for the run/step/halt sequencer.
//   state_e        : sequencer state, 3-bit encoding
//   CNT_W_DEFAULT  : default width of the statistics counters
//   PC_W           : width of the PC word address (PC[11:2])
// ---------------------------------------------------------------------------
package pc_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  localparam int unsigned CNT_W_DEFAULT = 32;
  localparam int unsigned PC_W          = 10;

endpackage

// File: rtl/pc_run_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// pc_run_ctrl_sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   in  1  clock, rising edge
//   rst   in  1  synchronous, active-high reset (count -> 0)
//   inc   in  1  add one this cycle
//   count out W  current count
// ---------------------------------------------------------------------------
module pc_run_ctrl_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pc_run_ctrl.sv
// ---------------------------------------------------------------------------
// pc_run_ctrl
// Run/step/halt sequencer for the single-cycle MIPS core. Generates the PC
// write-enable and counts retired instructions, taken branches and jumps.
// Optional feature macro: BREAKPOINT_EN (adds bp_valid/bp_addr/bp_hit).
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   go         in   1      run/step button (rising edge detected here)
//   step_mode  in   1      1 = single step per go edge, 0 = free run
//   halt_req   in   1      current instruction is the halt syscall
//   branch     in   1      current instruction is a taken branch
//   jmp        in   1      current instruction is J/JR/JAL
//   pc_addr    in   10     current PC word address
//   pc_enable  out  1      PC write-enable; instruction retires when 1
//   running    out  1      state is RUN
//   halted     out  1      state is HALT
//   cycle_cnt  out  CNT_W  retired-instruction count (saturating)
//   branch_cnt out  CNT_W  retired taken-branch count (saturating)
//   jmp_cnt    out  CNT_W  retired jump count (saturating)
//   bp_valid   in   1      [BREAKPOINT_EN] breakpoint armed
//   bp_addr    in   10     [BREAKPOINT_EN] breakpoint word address
//   bp_hit     out  1      [BREAKPOINT_EN] sticky break flag, cleared by go edge
// ---------------------------------------------------------------------------
module pc_run_ctrl
  import pc_run_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             step_mode,
  input  logic             halt_req,
  input  logic             branch,
  input  logic             jmp,
  input  logic [PC_W-1:0]  pc_addr,
  output logic             pc_enable,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] jmp_cnt
`ifdef BREAKPOINT_EN
  ,
  input  logic             bp_valid,
  input  logic [PC_W-1:0]  bp_addr,
  output logic             bp_hit
`endif
);

  state_e state_q, state_d;
  logic   go_q;
  logic   go_edge;
  logic   brk;
  logic   running_q, halted_q;

  assign go_edge = go & ~go_q;

`ifdef BREAKPOINT_EN
  logic skip_q;
  logic bp_hit_q;

  // Only free-running execution can break; skip_q lets the instruction we
  // paused on retire once after resuming.
  assign brk = (state_q == ST_RUN) & bp_valid & (pc_addr == bp_addr) & ~skip_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      skip_q   <= 1'b0;
      bp_hit_q <= 1'b0;
    end else begin
      if ((state_q == ST_PAUSE) && go_edge) begin
        skip_q <= 1'b1;
      end else if (pc_enable) begin
        skip_q <= 1'b0;
      end
      // A break in the same cycle as a go edge wins: the clearing edge must
      // come after the break.
      if (brk && !halt_req) begin
        bp_hit_q <= 1'b1;
      end else if (go_edge) begin
        bp_hit_q <= 1'b0;
      end
    end
  end

  assign bp_hit = bp_hit_q;
`else
  logic unused_pc_addr;
  assign unused_pc_addr = ^pc_addr;
  assign brk            = 1'b0;
`endif

  // Mealy enable: the halt syscall and a breakpointed instruction never
  // retire. Gated by rst so a reset cycle retires nothing.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_enable = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_RUN:  pc_enable = ~halt_req & ~brk;
        ST_STEP: pc_enable = ~halt_req;
        default: pc_enable = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_PAUSE: begin
        if (go_edge) state_d = step_mode ? ST_STEP : ST_RUN;
      end
      ST_RUN: begin
        if (halt_req)              state_d = ST_HALT;
        else if (brk || step_mode) state_d = ST_PAUSE;
      end
      ST_STEP: state_d = halt_req ? ST_HALT : ST_PAUSE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and its decoded status outputs are registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      go_q      <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      go_q      <= go;
      running_q <= (state_d == ST_RUN);
      halted_q  <= (state_d == ST_HALT);
    end
  end

  assign running = running_q;
  assign halted  = halted_q;

  pc_run_ctrl_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_enable),
    .count (cycle_cnt)
  );

  pc_run_ctrl_sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_enable & branch),
    .count (branch_cnt)
  );

  pc_run_ctrl_sat_counter #(.W(CNT_W)) u_jmp_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_enable & jmp),
    .count (jmp_cnt)
  );

endmodule

// File: tb/tb_pc_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_run_ctrl
// Self-checking bench for pc_run_ctrl. A wide (CNT_W=32) and a narrow
// (CNT_W=4) instance share all inputs; the narrow one exposes saturation.
// Breakpoint stimulus is compiled in when BREAKPOINT_EN is defined.
// ---------------------------------------------------------------------------
module tb_pc_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, go, step_mode, halt_req, branch, jmp;
  logic [9:0] pc_addr;
  logic        pc_enable, running, halted;
  logic [31:0] cycle_cnt, branch_cnt, jmp_cnt;
  logic        s_pc_enable, s_running, s_halted;
  logic [3:0]  s_cycle_cnt, s_branch_cnt, s_jmp_cnt;
`ifdef BREAKPOINT_EN
  logic       bp_valid;
  logic [9:0] bp_addr;
  logic       bp_hit, s_bp_hit;
`endif

  pc_run_ctrl #(.CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .go(go), .step_mode(step_mode), .halt_req(halt_req),
    .branch(branch), .jmp(jmp), .pc_addr(pc_addr), .pc_enable(pc_enable),
    .running(running), .halted(halted), .cycle_cnt(cycle_cnt),
    .branch_cnt(branch_cnt), .jmp_cnt(jmp_cnt)
`ifdef BREAKPOINT_EN
    , .bp_valid(bp_valid), .bp_addr(bp_addr), .bp_hit(bp_hit)
`endif
  );

  pc_run_ctrl #(.CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .go(go), .step_mode(step_mode), .halt_req(halt_req),
    .branch(branch), .jmp(jmp), .pc_addr(pc_addr), .pc_enable(s_pc_enable),
    .running(s_running), .halted(s_halted), .cycle_cnt(s_cycle_cnt),
    .branch_cnt(s_branch_cnt), .jmp_cnt(s_jmp_cnt)
`ifdef BREAKPOINT_EN
    , .bp_valid(bp_valid), .bp_addr(bp_addr), .bp_hit(s_bp_hit)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view: the core is either "executing" (m_active) or not; an
  // executing period is either free-running or a single step. Counters are
  // plain integers clamped at the counter maximum.
  bit m_active, m_single, m_halted, m_started, m_go_prev, m_skip, m_bp_hit;
  longint unsigned m_cyc, m_br, m_jmp;
  int unsigned m_pc;

  function automatic bit m_brk();
`ifdef BREAKPOINT_EN
    return m_active && !m_single && bp_valid && (pc_addr == bp_addr) && !m_skip;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_pe();
    return !rst && m_active && !halt_req && !m_brk();
  endfunction

  function automatic longint unsigned clamp(input longint unsigned v, input longint unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step();
    bit pe, brk, edge_seen;
    brk       = m_brk();
    pe        = m_pe();
    edge_seen = go && !m_go_prev;
    if (rst) begin
      {m_active, m_single, m_halted, m_started, m_go_prev, m_skip, m_bp_hit} = '0;
      m_cyc = 0; m_br = 0; m_jmp = 0; m_pc = 0;
    end else begin
      if (pe) begin
        m_cyc = clamp(m_cyc + 1, 64'hFFFF_FFFF);
        m_br  = clamp(m_br + branch, 64'hFFFF_FFFF);
        m_jmp = clamp(m_jmp + jmp, 64'hFFFF_FFFF);
        m_pc++;
      end
      if (brk && !halt_req) m_bp_hit = 1'b1;
      else if (edge_seen)   m_bp_hit = 1'b0;
      if (m_started && !m_active && !m_halted && edge_seen) m_skip = 1'b1;
      else if (pe)                                          m_skip = 1'b0;
      if (!m_halted) begin
        if (m_active) begin
          if (halt_req) begin
            m_halted = 1'b1;
            m_active = 1'b0;
          end else if (m_single || brk || step_mode) begin
            m_active = 1'b0;
          end
        end else if (edge_seen) begin
          m_active  = 1'b1;
          m_single  = step_mode;
          m_started = 1'b1;
        end
      end
      m_go_prev = go;
    end
  endtask

  task automatic check_all();
    check("pc_enable", pc_enable, m_pe());
    check("running", running, m_active && !m_single);
    check("halted", halted, m_halted);
    check("cycle_cnt", cycle_cnt, m_cyc);
    check("branch_cnt", branch_cnt, m_br);
    check("jmp_cnt", jmp_cnt, m_jmp);
    check("s_cycle_cnt", s_cycle_cnt, clamp(m_cyc, 15));
    check("s_branch_cnt", s_branch_cnt, clamp(m_br, 15));
    check("s_jmp_cnt", s_jmp_cnt, clamp(m_jmp, 15));
`ifdef BREAKPOINT_EN
    check("bp_hit", bp_hit, m_bp_hit);
`endif
  endtask

  logic tick_pe;

  // Outputs are sampled on the falling edge; inputs change just after the
  // rising edge.
  task automatic tick(input bit do_check);
    @(negedge clk);
    tick_pe = pc_enable;
    if (do_check) check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    go = 0; step_mode = 0; halt_req = 0; branch = 0; jmp = 0; pc_addr = '0;
`ifdef BREAKPOINT_EN
    bp_valid = 0; bp_addr = '0;
`endif
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick(0);
    tick(0);
    rst = 0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit        go, sm, halt, br, jp;
    bit        pe, run, hlt;
    int unsigned cyc, bcnt, jcnt;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int pe_ones;
    int guard;

    //          go sm hl br jp   pe run hlt cyc b  j
    vecs[0]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 1,  1, 1, 0, 1, 1, 0};
    vecs[4]  = '{0, 0, 0, 1, 1,  1, 1, 0, 2, 1, 1};
    vecs[5]  = '{0, 1, 0, 0, 0,  1, 1, 0, 3, 2, 2};
    vecs[6]  = '{0, 1, 0, 0, 0,  0, 0, 0, 4, 2, 2};
    vecs[7]  = '{1, 1, 0, 0, 0,  0, 0, 0, 4, 2, 2};
    vecs[8]  = '{1, 1, 0, 0, 0,  1, 0, 0, 4, 2, 2};
    vecs[9]  = '{0, 0, 0, 0, 0,  0, 0, 0, 5, 2, 2};
    vecs[10] = '{1, 0, 0, 0, 0,  0, 0, 0, 5, 2, 2};
    vecs[11] = '{0, 0, 1, 0, 0,  0, 1, 0, 5, 2, 2};
    vecs[12] = '{0, 0, 1, 0, 0,  0, 0, 1, 5, 2, 2};
    vecs[13] = '{1, 0, 1, 0, 0,  0, 0, 1, 5, 2, 2};
    vecs[14] = '{0, 0, 0, 0, 0,  0, 0, 1, 5, 2, 2};

    rst = 1;
    clear_inputs();
    @(posedge clk);
    #1;
    do_reset();

    // Reset state
    check("rst_pc_enable", pc_enable, 0);
    check("rst_running", running, 0);
    check("rst_halted", halted, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);

    foreach (vecs[i]) begin
      go = vecs[i].go; step_mode = vecs[i].sm; halt_req = vecs[i].halt;
      branch = vecs[i].br; jmp = vecs[i].jp;
      @(negedge clk);
      check($sformatf("vec%0d_pe", i), pc_enable, vecs[i].pe);
      check($sformatf("vec%0d_run", i), running, vecs[i].run);
      check($sformatf("vec%0d_halted", i), halted, vecs[i].hlt);
      check($sformatf("vec%0d_cyc", i), cycle_cnt, vecs[i].cyc);
      check($sformatf("vec%0d_br", i), branch_cnt, vecs[i].bcnt);
      check($sformatf("vec%0d_jmp", i), jmp_cnt, vecs[i].jcnt);
      model_step();
      @(posedge clk);
      #1;
    end

    // Free run: 10 retired cycles, 3 with a taken branch
    do_reset();
    go = 1; tick(1); go = 0;
    check("run_pe_next_cycle", pc_enable, 1);
    for (int i = 0; i < 10; i++) begin
      branch = (i == 2 || i == 5 || i == 7);
      tick(1);
    end
    branch = 0;
    check("run_cycle_cnt_10", cycle_cnt, 10);
    check("run_branch_cnt_3", branch_cnt, 3);

    // Single step with go held: exactly one retirement
    do_reset();
    step_mode = 1; go = 1;
    pe_ones = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (tick_pe) pe_ones++;
    end
    go = 0;
    check("step_pe_cycles", pe_ones, 1);
    check("step_cycle_cnt", cycle_cnt, 1);
    check("step_paused_not_running", running, 0);
    check("step_not_halted", halted, 0);

    // Halt at cycle 7: never retired, terminal
    do_reset();
    go = 1; tick(1); go = 0;
    for (int c = 1; c <= 7; c++) begin
      halt_req = (c == 7);
      tick(1);
    end
    check("halt_pe_on_syscall", tick_pe, 0);
    check("halt_halted", halted, 1);
    check("halt_cycle_cnt", cycle_cnt, 6);
    for (int i = 0; i < 3; i++) begin
      go = 1; tick(1);
      go = 0; tick(1);
    end
    check("halt_sticky", halted, 1);
    check("halt_cnt_frozen", cycle_cnt, 6);
    check("halt_pe_off", pc_enable, 0);
    halt_req = 0;

    // Saturation on the 4-bit instance; wide instance keeps counting
    do_reset();
    jmp = 1; go = 1; tick(1); go = 0;
    for (int i = 0; i < 20; i++) tick(1);
    check("sat_jmp_cnt", s_jmp_cnt, 4'hF);
    check("sat_cycle_cnt", s_cycle_cnt, 4'hF);
    check("wide_jmp_cnt", jmp_cnt, 20);
    jmp = 0;

    // Reset in the middle of a run
    check("pre_rst_running", running, 1);
    rst = 1; tick(1); rst = 0;
    check("midrst_running", running, 0);
    check("midrst_cycle_cnt", cycle_cnt, 0);
    check("midrst_jmp_cnt", jmp_cnt, 0);
    check("midrst_pe", pc_enable, 0);

`ifdef BREAKPOINT_EN
    // Breakpoint at word 5 with the PC counting up from 0
    do_reset();
    bp_valid = 1; bp_addr = 10'h005;
    go = 1;
    guard = 0;
    do begin
      pc_addr = m_pc[9:0];
      tick(1);
      go = 0;
      guard++;
    end while (running !== 1'b0 && guard < 2) || (running === 1'b1 && guard < 20);
    check("bp_pause_addr", pc_addr, 10'h005);
    check("bp_hit_set", bp_hit, 1);
    check("bp_paused", running, 0);
    check("bp_cycle_cnt", cycle_cnt, 5);
    go = 1; pc_addr = m_pc[9:0]; tick(1); go = 0;
    check("bp_hit_cleared", bp_hit, 0);
    pc_addr = m_pc[9:0];
    tick(1);
    check("bp_resume_retires", tick_pe, 1);
    check("bp_resume_cycle_cnt", cycle_cnt, 6);
    check("bp_still_running", running, 1);
`endif

    // Randomised run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(99) < 2);
      go        = ($urandom_range(99) < 30);
      step_mode = ($urandom_range(99) < 20);
      halt_req  = ($urandom_range(99) < 2);
      branch    = ($urandom_range(2) == 0);
      jmp       = ($urandom_range(3) == 0);
      pc_addr   = 10'($urandom_range(7));
`ifdef BREAKPOINT_EN
      bp_valid  = $urandom_range(1) == 1;
      bp_addr   = 10'($urandom_range(7));
`endif
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
